dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter MEM_AW, default 10, word-address width; memory is 2^MEM_AW 32-bit words (4 KB at default).
REQ-002 Parameter WAIT_STATES, default 1, extra stall cycles per access; legal range 0..15.
REQ-003 The block SHALL have one clock, CLK; reset is RES, asynchronous and active-high.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RES  input  1  asynchronous active-high reset.
REQ-006 DAS  input  1  access strobe from the pipeline's memory stage.
REQ-007 DRD  input  1  read request, qualified by DAS.
REQ-008 DWR  input  1  write request, qualified by DAS.
REQ-009 DRW  input  1  write direction flag; informational only, ignored.
REQ-010 DLEN  input  3  access size: 001 byte, 010 half, 100 word.
REQ-011 DADDR  input  32  byte address.
REQ-012 DATAO  input  32  write data, right-justified.
REQ-013 DATAI  output  32  read data, right-justified and unextended; the master does sign or zero extension.
REQ-014 HLT  output  1  stall to the pipeline; high means the access is not complete.
REQ-015 DERR  output  1  one-cycle pulse when an access completes as an error.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT, ACK.
REQ-017 IDLE: the block SHALL not leave IDLE while DAS=0.
REQ-018 IDLE with DAS=1: the block SHALL perform the RAM access on that edge and load the wait counter with WAIT_STATES.
REQ-019 The IDLE transition with DAS=1 SHALL go to ACK if WAIT_STATES=0, else to WAIT.
REQ-020 WAIT: the counter SHALL decrement each cycle; the FSM SHALL go to ACK when the counter reaches 1.
REQ-021 ACK: the FSM SHALL go unconditionally to IDLE on the next edge; an access still presented there is a new, back-to-back access.
REQ-022 HLT SHALL be combinational: 1 when (state=IDLE and DAS=1) or state=WAIT; 0 otherwise.
REQ-023 The resulting latency SHALL be WAIT_STATES+1 stalled cycles, then one HLT=0 cycle in which DATAI is valid.
REQ-024 The master holds DAS, DADDR, DLEN, DATAO, DRD and DWR stable while HLT=1; the block SHALL sample them only at the IDLE edge.
REQ-025 The word index SHALL be DADDR[MEM_AW+1:2]; higher address bits are ignored, so the memory aliases.
REQ-026 Read: DATAI SHALL be the addressed word shifted right by 8*DADDR[1:0], masked to 8, 16 or 32 bits per DLEN.
REQ-027 Read: DATAI SHALL be registered at the IDLE edge and held until the next access starts.
REQ-028 Write: only the addressed byte lanes SHALL be updated.
REQ-029 Byte write: DATAO[7:0] SHALL go to lane DADDR[1:0].
REQ-030 Half write: DATAO[15:0] SHALL go to lanes {DADDR[1],1'b1 : DADDR[1],1'b0}.
REQ-031 Word write: all four lanes SHALL be written.
REQ-032 DWR=1 and DRD=1 together SHALL be treated as a write.
REQ-033 DAS=1 with DRD=DWR=0 SHALL complete normally with no RAM change and DATAI=0.
REQ-034 An error SHALL be any of: a half access with DADDR[0]=1, a word access with DADDR[1:0]!=0, or a DLEN value not in {001,010,100}.
REQ-035 On an error the block SHALL perform no write, set DATAI=0, run the normal wait sequence, and pulse DERR=1 in ACK only.
REQ-036 Read-after-write to the same address in consecutive accesses SHALL return the new data; no bypass is needed because the RAM write completes before the next IDLE edge.

Reset
REQ-037 RES=1 SHALL asynchronously force state=IDLE, counter=0, DATAI=0 and DERR=0.
REQ-038 While RES=1, HLT SHALL be 0.
REQ-039 RAM contents SHALL NOT be reset.
REQ-040 A reset asserted mid-access SHALL abort the access; a write that was already clocked at the IDLE edge remains committed.
REQ-041 After RES deasserts with DAS=1, the access SHALL restart from IDLE.

Verification
REQ-042 Scenario 1, WAIT_STATES=1: word write 0xDEADBEEF to 0x40, then word read 0x40 -> HLT high 2 cycles per access; DATAI=0xDEADBEEF in the ACK cycle; DERR=0.
REQ-043 Scenario 2: byte write 0xA5 to 0x43, then word read 0x40 -> 0xA5ADBEEF; byte read 0x43 -> DATAI=0x000000A5; half read 0x42 -> 0x0000A5AD.
REQ-044 Scenario 3: half read 0x41 and word read 0x42 -> DERR pulses once per access; DATAI=0; a RAM spot-check shows no change.
REQ-045 Scenario 4, WAIT_STATES=0: back-to-back reads with DAS held high through 0x40 then 0x44 -> HLT pattern 1,0,1,0; correct data in each low cycle.
REQ-046 Scenario 5, WAIT_STATES=3: assert RES during WAIT of a read -> HLT drops immediately; after release, the held request completes with HLT high 4 cycles.
REQ-047 Scenario 6: alias check with MEM_AW=10 -> write at 0x1000 is read back at 0x0000.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Single-port data memory that answers the pipeline's memory stage. Each
// access stalls the pipeline for WAIT_STATES+1 cycles. It then drops HLT for
// one ACK cycle, in which DATAI holds the read result. Misaligned accesses and
// accesses with an illegal size complete without touching the RAM. They return
// zero and pulse DERR in the ACK cycle.
//
// Parameters
//   MEM_AW       word-address width; the RAM holds 2^MEM_AW 32-bit words
//   WAIT_STATES  extra stall cycles per access (0..15)
//
// Ports
//   CLK    in   1   clock, rising edge
//   RES    in   1   asynchronous active-high reset
//   DAS    in   1   access strobe
//   DRD    in   1   read request (qualified by DAS)
//   DWR    in   1   write request (qualified by DAS); wins over DRD
//   DRW    in   1   direction flag, unused
//   DLEN   in   3   access size: 001 byte, 010 half, 100 word
//   DADDR  in   32  byte address; bits above MEM_AW+1 alias
//   DATAO  in   32  right-justified write data
//   DATAI  out  32  right-justified, zero-filled read data
//   HLT    out  1   stall request; high while the access is incomplete
//   DERR   out  1   one-cycle error pulse in the ACK cycle
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        DAS,
    input  logic        DRD,
    input  logic        DWR,
    input  logic        DRW,
    input  logic [2:0]  DLEN,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    output logic [31:0] DATAI,
    output logic        HLT,
    output logic        DERR
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        err_q;

    logic [31:0] mem [2**MEM_AW];

    logic [MEM_AW-1:0] word_idx;
    logic        start;
    logic        acc_err;
    logic        do_write;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] rd_data;

    // DRW and the aliased upper address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{DRW, DADDR[31:MEM_AW+2]};

    assign word_idx = DADDR[MEM_AW+1:2];
    assign start    = (state == S_IDLE) && DAS;
    // Gating with RES keeps a clock edge during reset from committing a write.
    assign do_write = start && DWR && !acc_err && !RES;

    // -------------------------------------------------------------------------
    // Access decode: legality, byte-lane enables and lane-replicated write data
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so
        // no path through the case can leave it unassigned and infer a latch.
        acc_err = 1'b0;
        be      = 4'b0000;
        wdata   = DATAO;
        case (DLEN)
            3'b001: begin
                be    = 4'b0001 << DADDR[1:0];
                wdata = {4{DATAO[7:0]}};
            end
            3'b010: begin
                acc_err = DADDR[0];
                be      = DADDR[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{DATAO[15:0]}};
            end
            3'b100: begin
                acc_err = |DADDR[1:0];
                be      = 4'b1111;
            end
            default: acc_err = 1'b1;
        endcase
    end

    // Read path: align the addressed bytes to bit 0, then clear unused lanes.
    always_comb begin
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {DADDR[1:0], 3'b000};
        case (DLEN)
            3'b001:  rd_data = {24'h0, rd_shift[7:0]};
            3'b010:  rd_data = {16'h0, rd_shift[15:0]};
            default: rd_data = rd_shift;
        endcase
    end

    // -------------------------------------------------------------------------
    // RAM
    // -------------------------------------------------------------------------
    // NOTE: the RAM array has no reset branch; its contents survive RES and the
    // array can map onto a block RAM.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register (with wait counter and registered read data)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            DATAI <= 32'h0;
            err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every
            // register samples its pre-edge inputs, whatever the statement order.
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                DATAI <= (DRD && !DWR && !acc_err) ? rd_data : 32'h0;
                err_q <= acc_err;
            end
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (DAS) begin
                    cnt_nxt   = WS;
                    state_nxt = (WS == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                // The <= guard also covers a counter that is already at zero.
                if (cnt <= 4'd1) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. HLT is forced low while RES is high, even when DAS is high.
    always_comb begin
        HLT  = !RES && (start || (state == S_WAIT));
        DERR = (state == S_ACK) && err_q;
    end

endmodule
